// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : i2c_pkg                                                    |
// | Description : Shared constants for the 7-bit I2C target: state codes,    |
// |               ACK/NACK bus levels, R/W bit values and byte width.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;

    // Bus level of the ninth (acknowledge) bit
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Value of the R/W bit in the address byte
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Target state machine encoding
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_addr     = 3'd1;
    localparam logic [2:0] c_st_addr_ack = 3'd2;
    localparam logic [2:0] c_st_wr_data  = 3'd3;
    localparam logic [2:0] c_st_wr_ack   = 3'd4;
    localparam logic [2:0] c_st_rd_data  = 3'd5;
    localparam logic [2:0] c_st_rd_ack   = 3'd6;
    localparam logic [2:0] c_st_ignore   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : i2c_line_sync                                              |
// | Description : Synchronizes the SCL/SDA pins into the clk domain and      |
// |               reports SCL edges plus START/STOP conditions. Flops reset  |
// |               to 1 so a reset never fabricates a bus event.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // Synchronizer chains plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    // START/STOP qualify on SCL high in both the current and previous sample
    assign sda       = w_sda;
    assign scl_rise  =  w_scl & ~r_scl_d;
    assign scl_fall  = ~w_scl &  r_scl_d;
    assign start_det =  w_scl &  r_scl_d &  r_sda_d & ~w_sda;
    assign stop_det  =  w_scl &  r_scl_d & ~r_sda_d &  w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : i2c_target                                                 |
// | Description : 7-bit addressed I2C target. ACKs OWN_ADDR, delivers       |
// |               written bytes on rx_data/rx_valid. Defining the macro      |
// |               I2C_TARGET_READ_EN builds the read path (tx_data/tx_req);  |
// |               otherwise read requests are NACKed.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  addr_match,
    output logic                  busy
);

    logic                  w_sda;
    logic                  w_scl_rise;
    logic                  w_scl_fall;
    logic                  w_start;
    logic                  w_stop;
    logic [2:0]            r_state;
    logic [2:0]            r_bit_cnt;
    logic [I2C_BYTE_W-2:0] r_shift;
    logic                  r_drive;
    logic [I2C_BYTE_W-1:0] w_byte;
    logic                  w_addr_hit;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (w_sda),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    // Byte as it stands once the current bit is shifted in
    assign w_byte = {r_shift, w_sda};

`ifdef I2C_TARGET_READ_EN
    logic                  r_rw;
    logic                  r_load;
    logic [I2C_BYTE_W-2:0] r_tx_shift;
    assign w_addr_hit = (w_byte[7:1] == OWN_ADDR);
`else
    // Without the read path a read to our address is simply not acknowledged
    logic w_unused_tx;
    assign w_unused_tx = ^tx_data;
    assign w_addr_hit  = (w_byte[7:1] == OWN_ADDR) && (w_byte[0] == RW_WRITE);
`endif

    // Protocol FSM; r_drive is the SDA pull request, re-timed once into sda_oe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_bit_cnt  <= 3'd0;
            r_shift    <= '0;
            r_drive    <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            r_rw       <= RW_WRITE;
            r_load     <= 1'b0;
            r_tx_shift <= '0;
`endif
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            sda_oe   <= r_drive;
            if (w_start) begin
                r_state    <= c_st_addr;
                r_bit_cnt  <= 3'd0;
                r_drive    <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b1;
`ifdef I2C_TARGET_READ_EN
                r_load     <= 1'b0;
`endif
            end else if (w_stop) begin
                r_state    <= c_st_idle;
                r_drive    <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b0;
`ifdef I2C_TARGET_READ_EN
                r_load     <= 1'b0;
`endif
            end else begin
                case (r_state)
                    c_st_addr: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[I2C_BYTE_W-2:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (w_addr_hit) begin
                                    r_state    <= c_st_addr_ack;
                                    addr_match <= 1'b1;
`ifdef I2C_TARGET_READ_EN
                                    r_rw       <= w_byte[0];
`endif
                                end else begin
                                    r_state <= c_st_ignore;
                                end
                            end
                        end
                    end
                    // First fall pulls SDA for the ACK, second fall ends it
                    c_st_addr_ack: begin
                        if (w_scl_fall) begin
                            if (!r_drive) begin
                                r_drive <= 1'b1;
                            end else begin
                                r_drive <= 1'b0;
                                r_state <= c_st_wr_data;
`ifdef I2C_TARGET_READ_EN
                                if (r_rw == RW_READ) begin
                                    r_state    <= c_st_rd_data;
                                    r_tx_shift <= tx_data[I2C_BYTE_W-2:0];
                                    r_drive    <= ~tx_data[I2C_BYTE_W-1];
                                    tx_req     <= 1'b1;
                                end
`endif
                            end
                        end
                    end
                    c_st_wr_data: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[I2C_BYTE_W-2:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                rx_data  <= w_byte;
                                rx_valid <= 1'b1;
                                r_state  <= c_st_wr_ack;
                            end
                        end
                    end
                    c_st_wr_ack: begin
                        if (w_scl_fall) begin
                            r_drive <= ~r_drive;
                            if (r_drive) begin
                                r_state <= c_st_wr_data;
                            end
                        end
                    end
`ifdef I2C_TARGET_READ_EN
                    // r_load marks the fall that ends an initiator ACK
                    c_st_rd_data: begin
                        if (w_scl_fall) begin
                            if (r_load) begin
                                r_load     <= 1'b0;
                                r_tx_shift <= tx_data[I2C_BYTE_W-2:0];
                                r_drive    <= ~tx_data[I2C_BYTE_W-1];
                                tx_req     <= 1'b1;
                            end else begin
                                r_tx_shift <= {r_tx_shift[I2C_BYTE_W-3:0], 1'b0};
                                r_drive    <= ~r_tx_shift[I2C_BYTE_W-2];
                            end
                        end else if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= c_st_rd_ack;
                            end
                        end
                    end
                    c_st_rd_ack: begin
                        if (w_scl_fall) begin
                            r_drive <= 1'b0;
                        end else if (w_scl_rise) begin
                            if (w_sda == I2C_ACK) begin
                                r_state <= c_st_rd_data;
                                r_load  <= 1'b1;
                            end else begin
                                r_state <= c_st_ignore;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_i2c_target                                              |
// | Description : Self-checking bench for i2c_target. Acts as the I2C        |
// |               initiator on a wired-AND SDA line and checks results       |
// |               against expectations derived from the bus protocol.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_i2c_target;

    localparam logic [6:0] OWN = 7'h42;
`ifdef I2C_TARGET_READ_EN
    localparam logic READ_EN = 1'b1;
`else
    localparam logic READ_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl   = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       addr_match;
    logic       busy;
    logic [7:0] tx_data;
    logic       sda_bus;

    int checks = 0;
    int errors = 0;

    // Monitor state, written only by the monitor process
    int         rx_cnt     = 0;
    int         txreq_cnt  = 0;
    int         oe_hi_cnt  = 0;
    int         oe_bad     = 0;
    logic       prev_oe    = 1'b0;
    logic [7:0] rx_q[$];

    // Read bytes offered to the target, indexed by tx_req count
    logic [7:0] tx_tab [0:3];

    assign sda_bus = m_sda & ~sda_oe;
    assign tx_data = tx_tab[txreq_cnt[1:0]];

    always #5 clk = ~clk;

    i2c_target #(
        .OWN_ADDR    (OWN),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl),
        .sda_i      (sda_bus),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .addr_match (addr_match),
        .busy       (busy)
    );

    // Observe outputs on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_q.push_back(rx_data);
        end
        if (tx_req) txreq_cnt++;
        if (sda_oe) oe_hi_cnt++;
        if (sda_oe !== prev_oe && scl && rst_n) oe_bad++;
        prev_oe = sda_oe;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START (also used as repeated START): SDA falls while SCL is high
    task automatic i2c_start();
        wait_clk(2);
        scl = 1'b0;
        wait_clk(6);
        m_sda = 1'b1;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(8);
        m_sda = 1'b0;
        wait_clk(8);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        scl = 1'b0;
        wait_clk(6);
        m_sda = 1'b0;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(8);
        m_sda = 1'b1;
        wait_clk(8);
    endtask

    // One SCL clock: drive b during low phase, sample the wired bus when high
    task automatic i2c_bit(input logic b, output logic s);
        wait_clk(6);
        m_sda = b;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(5);
        s = sda_bus;
        wait_clk(5);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
        i2c_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack_in, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            b[i] = s;
        end
        i2c_bit(ack_in, s);
    endtask

    task automatic test_reset();
        wait_clk(3);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%0b exp=0", sda_oe); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%0h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%0b exp=0", rx_valid); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req got=%0b exp=0", tx_req); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL reset_addr_match got=%0b exp=0", addr_match); end
        rst_n = 1'b1;
        wait_clk(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_write();
        logic ack;
        int   c0 = rx_cnt;
        i2c_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_start got=%0b exp=1", busy); end
        send_byte(8'h84, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got=%0b exp=0", ack); end
        checks++; if (addr_match !== 1'b1) begin errors++; $display("FAIL wr_addr_match got=%0b exp=1", addr_match); end
        send_byte(8'hA4, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack got=%0b exp=0", ack); end
        checks++; if (rx_cnt - c0 !== 1) begin errors++; $display("FAIL wr_rx_pulses got=%0d exp=1", rx_cnt - c0); end
        checks++; if (rx_data !== 8'hA4) begin errors++; $display("FAIL wr_rx_data got=%0h exp=a4", rx_data); end
        i2c_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got=%0b exp=0", busy); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL wr_match_stop got=%0b exp=0", addr_match); end
    endtask

    task automatic test_wrong_addr();
        logic ack;
        int   c0 = rx_cnt;
        int   o0 = oe_hi_cnt;
        i2c_start();
        send_byte(8'h86, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wa_addr_ack got=%0b exp=1", ack); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL wa_addr_match got=%0b exp=0", addr_match); end
        send_byte(8'h55, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wa_data_ack got=%0b exp=1", ack); end
        i2c_stop();
        checks++; if (oe_hi_cnt !== o0) begin errors++; $display("FAIL wa_sda_driven got=%0d exp=%0d", oe_hi_cnt, o0); end
        checks++; if (rx_cnt !== c0) begin errors++; $display("FAIL wa_rx_pulses got=%0d exp=%0d", rx_cnt, c0); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] b;
        int         t0 = txreq_cnt;
        tx_tab[t0[1:0]]         = 8'h3C;
        tx_tab[t0[1:0] + 2'd1]  = 8'hC3;
        i2c_start();
        send_byte(8'h85, ack);
        checks++; if (ack !== ~READ_EN) begin errors++; $display("FAIL rd_addr_ack got=%0b exp=%0b", ack, ~READ_EN); end
        checks++; if (addr_match !== READ_EN) begin errors++; $display("FAIL rd_addr_match got=%0b exp=%0b", addr_match, READ_EN); end
`ifdef I2C_TARGET_READ_EN
        recv_byte(1'b0, b);
        checks++; if (b !== 8'h3C) begin errors++; $display("FAIL rd_byte0 got=%0h exp=3c", b); end
        recv_byte(1'b1, b);
        checks++; if (b !== 8'hC3) begin errors++; $display("FAIL rd_byte1 got=%0h exp=c3", b); end
        checks++; if (txreq_cnt - t0 !== 2) begin errors++; $display("FAIL rd_tx_req got=%0d exp=2", txreq_cnt - t0); end
`endif
        // After a NACK (or an unacknowledged read) the target must stay off the bus
        recv_byte(1'b1, b);
        checks++; if (b !== 8'hFF) begin errors++; $display("FAIL rd_passive got=%0h exp=ff", b); end
        checks++; if (txreq_cnt - t0 !== (READ_EN ? 2 : 0)) begin errors++; $display("FAIL rd_tx_req_total got=%0d exp=%0d", txreq_cnt - t0, READ_EN ? 2 : 0); end
        i2c_stop();
    endtask

    task automatic test_back_to_back();
        logic       ack;
        logic [7:0] b;
        int         t0 = txreq_cnt;
        tx_tab[t0[1:0]] = 8'h5A;
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(8'hA4, ack);
        i2c_start();
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL rs_match_clear got=%0b exp=0", addr_match); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy got=%0b exp=1", busy); end
        checks++; if (rx_data !== 8'hA4) begin errors++; $display("FAIL rs_rx_data got=%0h exp=a4", rx_data); end
        send_byte(8'h85, ack);
        checks++; if (ack !== ~READ_EN) begin errors++; $display("FAIL rs_read_ack got=%0b exp=%0b", ack, ~READ_EN); end
        recv_byte(1'b1, b);
        checks++; if (b !== (READ_EN ? 8'h5A : 8'hFF)) begin errors++; $display("FAIL rs_read_byte got=%0h exp=%0h", b, READ_EN ? 8'h5A : 8'hFF); end
        i2c_stop();
    endtask

    task automatic test_stop_mid();
        logic ack;
        logic s;
        int   c0;
        i2c_start();
        send_byte(8'h84, ack);
        c0 = rx_cnt;
        for (int i = 0; i < 4; i++) i2c_bit(1'b1, s);
        i2c_stop();
        checks++; if (rx_cnt !== c0) begin errors++; $display("FAIL sm_rx_pulses got=%0d exp=%0d", rx_cnt, c0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sm_busy got=%0b exp=0", busy); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL sm_match got=%0b exp=0", addr_match); end
    endtask

    task automatic test_reset_mid();
        logic ack;
        logic s;
        i2c_start();
        for (int i = 7; i >= 0; i--) i2c_bit(logic'((8'h84 >> i) & 8'h01), s);
        // Enter the ACK clock and pull reset while the target holds SDA low
        wait_clk(6);
        m_sda = 1'b1;
        wait_clk(6);
        scl = 1'b1;
        wait_clk(2);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rm_ack_driven got=%0b exp=1", sda_oe); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rm_sda_oe got=%0b exp=0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%0b exp=0", busy); end
        checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL rm_match got=%0b exp=0", addr_match); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rm_rx_data got=%0h exp=00", rx_data); end
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        i2c_stop();
        i2c_start();
        send_byte(8'h84, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rm_addr_ack got=%0b exp=0", ack); end
        send_byte(8'h3E, ack);
        checks++; if (rx_data !== 8'h3E) begin errors++; $display("FAIL rm_rx_data_after got=%0h exp=3e", rx_data); end
        i2c_stop();
    endtask

    // Random write traffic against a transaction-level model of the target
    task automatic test_random();
        logic       ack;
        logic       exp_ack;
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] exp_q[$];
        int         base = rx_q.size();
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = OWN;
            end else begin
                a = 7'($urandom);
                if (a == OWN) a = a ^ 7'h01;
            end
            exp_ack = (a == OWN) ? 1'b0 : 1'b1;
            i2c_start();
            send_byte({a, 1'b0}, ack);
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rnd_addr_ack t=%0d addr=%0h got=%0b exp=%0b", t, a, ack, exp_ack); end
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                d = 8'($urandom);
                send_byte(d, ack);
                checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rnd_data_ack t=%0d got=%0b exp=%0b", t, ack, exp_ack); end
                if (a == OWN) exp_q.push_back(d);
            end
            if ($urandom_range(0, 2) != 0) i2c_stop();
        end
        i2c_stop();
        checks++; if (rx_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL rnd_rx_count got=%0d exp=%0d", rx_q.size() - base, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && base + k < rx_q.size(); k++) begin
            checks++; if (rx_q[base + k] !== exp_q[k]) begin errors++; $display("FAIL rnd_rx_data idx=%0d got=%0h exp=%0h", k, rx_q[base + k], exp_q[k]); end
        end
    endtask

    task automatic test_oe_timing();
        checks++; if (oe_bad !== 0) begin errors++; $display("FAIL oe_change_scl_high got=%0d exp=0", oe_bad); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tx_tab[i] = 8'h00;
        test_reset();
        test_write();
        test_wrong_addr();
        test_read();
        test_back_to_back();
        test_stop_mid();
        test_reset_mid();
        test_random();
        test_oe_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
